// File: rtl/frame_stack.sv
// frame_stack: LIFO of DEPTH 256-bit register-file frames (call pushes, ret pops). Optional sticky err via FRAME_STACK_ERR_EN.
// Latency: push stored at the call edge; popped frame and restore pulse are registered, 1 cycle after ret.
// Backpressure: none; overflow, underflow and call+ret conflicts are dropped, and full/empty come from the registered count.
module frame_stack #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       call,
  input  logic                       ret,
  input  logic [255:0]               frameIn,
  output logic [255:0]               frameOut,
  output logic                       restore,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [255:0]  mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   top_cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = call & ~ret & ~full;
  assign pop_ok  = ret & ~call & ~empty;
  assign top_cnt = count - 1'b1;
  assign wr_idx  = count[AW-1:0];
  assign rd_idx  = top_cnt[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      restore  <= 1'b0;
      frameOut <= '0;
    end else begin
      restore <= pop_ok;
      if (push_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok) begin
        count    <= top_cnt;
        frameOut <= mem[rd_idx];
      end
    end
  end

  // Frame storage is deliberately not reset: slots above count are never read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= frameIn;
    end
  end

`ifdef FRAME_STACK_ERR_EN
  logic err_q;
  logic proto_err;

  assign proto_err = (call & ret) | (call & ~ret & full) | (ret & ~call & empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (proto_err) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_stack.sv
// Self-checking bench for frame_stack: directed scenarios then random call/ret traffic against a queue-based LIFO model.
module tb_frame_stack;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst_n;
  logic           call;
  logic           ret;
  logic [255:0]   frameIn;
  logic [255:0]   frameOut;
  logic           restore;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           err;

  frame_stack #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .call     (call),
    .ret      (ret),
    .frameIn  (frameIn),
    .frameOut (frameOut),
    .restore  (restore),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [255:0] m_stk[$];
  logic [255:0] m_out;
  logic         m_restore;
  logic         m_err;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    logic [255:0] c_exp;
    c_exp = 256'(m_stk.size());
    check({tag, ".count"}, 256'(count), c_exp);
    check({tag, ".full"}, 256'(full), 256'(m_stk.size() == DEPTH));
    check({tag, ".empty"}, 256'(empty), 256'(m_stk.size() == 0));
    check({tag, ".restore"}, 256'(restore), 256'(m_restore));
    check({tag, ".frameOut"}, frameOut, m_out);
`ifdef FRAME_STACK_ERR_EN
    check({tag, ".err"}, 256'(err), 256'(m_err));
`else
    check({tag, ".err"}, 256'(err), 256'(1'b0));
`endif
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_out = '0;
    m_restore = 1'b0;
    m_err = 1'b0;
  endtask

  // Drive one cycle of request, apply the spec rules to the model, then check.
  task automatic step(input string tag, input logic c, input logic r, input logic [255:0] f);
    call = c;
    ret = r;
    frameIn = f;
    @(posedge clk);
    m_restore = 1'b0;
    if (c && r) begin
      m_err = 1'b1;
    end else if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(f);
      else m_err = 1'b1;
    end else if (r) begin
      if (m_stk.size() > 0) begin
        m_out = m_stk.pop_back();
        m_restore = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
    call = 1'b0;
    ret = 1'b0;
    frameIn = ~f;
    check_all(tag);
  endtask

  function automatic logic [255:0] lanes(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    rst_n = 1'b1;
    call = 1'b0;
    ret = 1'b0;
    frameIn = '0;
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three pushes, three back-to-back pops.
    for (int k = 1; k <= 3; k++) step("push3", 1'b1, 1'b0, lanes(16'(k)));
    for (int k = 0; k < 3; k++) step("pop3", 1'b0, 1'b1, '0);
    step("idle_after_pop", 1'b0, 1'b0, '0);

    // Fill past full, then drain.
    for (int k = 0; k < DEPTH + 1; k++) step("fill", 1'b1, 1'b0, lanes(16'(k + 16'h10)));
    for (int k = 0; k < DEPTH; k++) step("drain", 1'b0, 1'b1, '0);

    // Underflow.
    step("underflow", 1'b0, 1'b1, '0);
    step("underflow_idle", 1'b0, 1'b0, '0);

    // Conflict at count 2, then pop returns the second frame.
    step("c_push", 1'b1, 1'b0, lanes(16'h00a0));
    step("c_push", 1'b1, 1'b0, lanes(16'h00a1));
    step("conflict", 1'b1, 1'b1, lanes(16'hdead));
    step("c_pop", 1'b0, 1'b1, '0);
    step("c_pop", 1'b0, 1'b1, '0);

    // Push right after pop reuses the freed slot.
    step("reuse", 1'b1, 1'b0, lanes(16'h0b00));
    step("reuse", 1'b0, 1'b1, '0);
    step("reuse", 1'b1, 1'b0, lanes(16'h0b01));
    step("reuse", 1'b0, 1'b1, '0);

    // Reset while a restore pulse is pending.
    step("rst_push", 1'b1, 1'b0, lanes(16'h0c00));
    step("rst_push", 1'b1, 1'b0, lanes(16'h0c01));
    step("rst_pop", 1'b0, 1'b1, '0);
    rst_n = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_push", 1'b1, 1'b0, lanes(16'h0d00));
    step("post_rst_pop", 1'b0, 1'b1, '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: step("rand_call", 1'b1, 1'b0, rand_frame());
        4, 5, 6, 7: step("rand_ret", 1'b0, 1'b1, rand_frame());
        8:          step("rand_both", 1'b1, 1'b1, rand_frame());
        default:    step("rand_idle", 1'b0, 1'b0, rand_frame());
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
